// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, depth and read-source priority for register_file_2w
// Optional build macro REG0_ZERO_EN is consumed by register_file_2w and its bench.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    SRC_STORE = 2'd0,
    SRC_PORT1 = 2'd1,
    SRC_PORT2 = 2'd2
  } rd_src_e;

  // Port 1 beats port 2, which beats storage; the same order governs writes.
  function automatic rd_src_e rd_src_sel(input logic hit1, input logic hit2);
    if (hit1) return SRC_PORT1;
    if (hit2) return SRC_PORT2;
    return SRC_STORE;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-result busy vector, bypassed busy reads and busy count
// Callers pass already-masked write/reserve enables (REG0_ZERO_EN masking lives in the top).
module regfile_scoreboard #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              clr1_en,
  input  logic [ADDR_W-1:0] clr1_reg,
  input  logic              clr2_en,
  input  logic [ADDR_W-1:0] clr2_reg,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  output logic              read_busy1,
  output logic              read_busy2,
  output logic [ADDR_W:0]   busy_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  busy_count_q, busy_count_d;
  logic [DEPTH-1:0] clr_hit, set_hit;

  always_comb begin
    clr_hit = '0;
    set_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      clr_hit[i] = (clr1_en && clr1_reg == ADDR_W'(i)) || (clr2_en && clr2_reg == ADDR_W'(i));
      set_hit[i] = set_en && set_reg == ADDR_W'(i);
    end
  end

  // Set wins over clear so a same-cycle reserve keeps the register pending.
  always_comb begin
    busy_d       = (busy_q & ~clr_hit) | set_hit;
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + (ADDR_W + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  always_comb begin
    read_busy1 = busy_q[read_reg1] & (~clr_hit[read_reg1] | set_hit[read_reg1]);
    read_busy2 = busy_q[read_reg2] & (~clr_hit[read_reg2] | set_hit[read_reg2]);
  end

  assign busy_count = busy_count_q;

endmodule

// File: rtl/register_file_2w.sv
// rtl/register_file_2w.sv - two-write-port register file with write-through bypass and scoreboard
// Define REG0_ZERO_EN to hardwire register 0 to zero (never written, never pending).
module register_file_2w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_busy1,
  output logic              read_busy2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write2_reg,
  input  logic [DATA_W-1:0] write2_data,
  input  logic              write2_en,
  input  logic [ADDR_W-1:0] reserve_reg,
  input  logic              reserve_en,
  output logic [ADDR_W:0]   busy_count
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef REG0_ZERO_EN
  localparam logic REG0_ZERO = 1'b1;
`else
  localparam logic REG0_ZERO = 1'b0;
`endif

  logic              we1, we2, rsv;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  always_comb begin
    we1 = write_en   & ~(REG0_ZERO & (write_reg   == '0));
    we2 = write2_en  & ~(REG0_ZERO & (write2_reg  == '0));
    rsv = reserve_en & ~(REG0_ZERO & (reserve_reg == '0));
  end

  // Port 2 is applied first so a colliding port-1 write overwrites it.
  always_comb begin
    regs_d = regs_q;
    if (we2) regs_d[write2_reg] = write2_data;
    if (we1) regs_d[write_reg]  = write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    case (rd_src_sel(we1 && write_reg == addr, we2 && write2_reg == addr))
      SRC_PORT1: data = write_data;
      SRC_PORT2: data = write2_data;
      default:   data = regs_q[addr];
    endcase
    if (REG0_ZERO && addr == '0) data = '0;
    return data;
  endfunction

  always_comb begin
    read_data1 = bypass_read(read_reg1);
    read_data2 = bypass_read(read_reg2);
  end

  regfile_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .clr1_en    (we1),
    .clr1_reg   (write_reg),
    .clr2_en    (we2),
    .clr2_reg   (write2_reg),
    .set_en     (rsv),
    .set_reg    (reserve_reg),
    .read_busy1 (read_busy1),
    .read_busy2 (read_busy2),
    .busy_count (busy_count)
  );

endmodule

// File: tb/tb_register_file_2w.sv
// tb/tb_register_file_2w.sv - directed vector table plus randomized reference-model check
// Honors REG0_ZERO_EN the same way as the design build.
module tb_register_file_2w;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] read_reg1, read_reg2, write_reg, write2_reg, reserve_reg;
  logic [DW-1:0] read_data1, read_data2, write_data, write2_data;
  logic          read_busy1, read_busy2, write_en, write2_en, reserve_en;
  logic [AW:0]   busy_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  register_file_2w #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .read_busy1(read_busy1), .read_busy2(read_busy2),
    .write_reg(write_reg), .write_data(write_data), .write_en(write_en),
    .write2_reg(write2_reg), .write2_data(write2_data), .write2_en(write2_en),
    .reserve_reg(reserve_reg), .reserve_en(reserve_en),
    .busy_count(busy_count)
  );

  typedef struct {
    logic          rst;
    logic          wen;  logic [AW-1:0] wreg;  logic [DW-1:0] wdata;
    logic          w2en; logic [AW-1:0] w2reg; logic [DW-1:0] w2data;
    logic          ren;  logic [AW-1:0] rreg;
    logic [AW-1:0] r1, r2;
    logic [DW-1:0] d1, d2;
    logic          b1, b2;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic we2, input logic [AW-1:0] wa2, input logic [DW-1:0] wd2,
                       input logic re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rst = r;
    write_en = we;    write_reg = wa;    write_data = wd;
    write2_en = we2;  write2_reg = wa2;  write2_data = wd2;
    reserve_en = re;  reserve_reg = ra;
    read_reg1 = a1;   read_reg2 = a2;
  endtask

  function automatic vec_t mk(input logic r, input logic we, input int wa, input int wd,
                              input logic we2, input int wa2, input int wd2,
                              input logic re, input int ra, input int a1, input int a2,
                              input int d1, input int d2, input logic b1, input logic b2, input int cnt);
    vec_t v;
    v.rst = r; v.wen = we; v.wreg = AW'(wa); v.wdata = DW'(wd);
    v.w2en = we2; v.w2reg = AW'(wa2); v.w2data = DW'(wd2);
    v.ren = re; v.rreg = AW'(ra); v.r1 = AW'(a1); v.r2 = AW'(a2);
    v.d1 = DW'(d1); v.d2 = DW'(d2); v.b1 = b1; v.b2 = b2; v.cnt = (AW + 1)'(cnt);
    return v;
  endfunction

  // Reference model state: plain arrays updated by the stated rules.
  int  m_reg  [DEPTH];
  bit  m_busy [DEPTH];

  function automatic bit is_zero_reg(input int r);
`ifdef REG0_ZERO_EN
    return r == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_data(input int r);
    if (is_zero_reg(r)) return 0;
    if (write_en && int'(write_reg) == r) return int'(write_data);
    if (write2_en && int'(write2_reg) == r) return int'(write2_data);
    return m_reg[r];
  endfunction

  function automatic bit model_busy(input int r);
    bit wr_hit, rsv_hit;
    if (is_zero_reg(r)) return 1'b0;
    wr_hit  = (write_en && int'(write_reg) == r) || (write2_en && int'(write2_reg) == r);
    rsv_hit = reserve_en && int'(reserve_reg) == r;
    return m_busy[r] && (!wr_hit || rsv_hit);
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (is_zero_reg(i)) continue;
      if (write2_en && int'(write2_reg) == i) begin m_reg[i] = int'(write2_data); m_busy[i] = 0; end
      if (write_en && int'(write_reg) == i)   begin m_reg[i] = int'(write_data);  m_busy[i] = 0; end
      if (reserve_en && int'(reserve_reg) == i) m_busy[i] = 1;
    end
  endtask

  initial begin
    //          rst we wa wd   we2 wa2 wd2  re ra a1 a2 d1    d2    b1 b2 cnt
    vecs[0]  = mk(0, 1, 3, 'hA5, 0, 0, 0,    0, 0, 3, 2, 'hA5, 'h00, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,    0, 0, 0,    1, 1, 3, 3, 'hA5, 'hA5, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0,    0, 0, 0,    0, 0, 3, 1, 'h00, 'h00, 0, 0, 0);
    vecs[3]  = mk(0, 1, 2, 'h11, 1, 2, 'h22, 0, 0, 2, 2, 'h11, 'h11, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,    1, 5, 'h3C, 0, 0, 2, 5, 'h11, 'h3C, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0,    0, 0, 0,    1, 4, 5, 2, 'h3C, 'h11, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0,    0, 0, 0,    0, 0, 4, 4, 'h00, 'h00, 1, 1, 1);
    vecs[7]  = mk(0, 1, 4, 'h7E, 0, 0, 0,    0, 0, 4, 5, 'h7E, 'h3C, 0, 0, 1);
    vecs[8]  = mk(0, 1, 6, 'h99, 0, 0, 0,    1, 6, 4, 6, 'h7E, 'h99, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0,    1, 7, 'h42, 1, 7, 6, 6, 'h99, 'h99, 1, 1, 1);
    vecs[10] = mk(0, 0, 0, 0,    0, 0, 0,    1, 6, 7, 6, 'h42, 'h99, 1, 1, 2);
    vecs[11] = mk(0, 0, 0, 0,    1, 6, 'h5A, 0, 0, 6, 7, 'h5A, 'h42, 0, 1, 2);
    vecs[12] = mk(0, 1, 7, 'h01, 1, 7, 'h02, 1, 7, 7, 6, 'h01, 'h5A, 1, 0, 1);
    vecs[13] = mk(0, 0, 0, 0,    0, 0, 0,    0, 0, 7, 7, 'h01, 'h01, 1, 1, 1);
`ifdef REG0_ZERO_EN
    vecs[14] = mk(0, 1, 0, 'hFF, 0, 0, 0,    1, 0, 0, 0, 'h00, 'h00, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 'h00, 'h00, 0, 0, 1);
`else
    vecs[14] = mk(0, 1, 0, 'hFF, 0, 0, 0,    1, 0, 0, 0, 'hFF, 'hFF, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 'hFF, 'hFF, 1, 1, 2);
`endif

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_count", 0, 32'(busy_count), 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].wen, vecs[i].wreg, vecs[i].wdata,
            vecs[i].w2en, vecs[i].w2reg, vecs[i].w2data,
            vecs[i].ren, vecs[i].rreg, vecs[i].r1, vecs[i].r2);
      #1;
      check("vec_data1", i, 32'(read_data1), 32'(vecs[i].d1));
      check("vec_data2", i, 32'(read_data2), 32'(vecs[i].d2));
      check("vec_busy1", i, 32'(read_busy1), 32'(vecs[i].b1));
      check("vec_busy2", i, 32'(read_busy2), 32'(vecs[i].b2));
      check("vec_count", i, 32'(busy_count), 32'(vecs[i].cnt));
    end

    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    model_edge();

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive(($urandom_range(0, 49) == 0), 1'($urandom), AW'($urandom), DW'($urandom),
            1'($urandom), AW'($urandom), DW'($urandom),
            ($urandom_range(0, 2) == 0), AW'($urandom), AW'($urandom), AW'($urandom));
      #1;
      check("rnd_data1", n, 32'(read_data1), 32'(model_data(int'(read_reg1))));
      check("rnd_data2", n, 32'(read_data2), 32'(model_data(int'(read_reg2))));
      check("rnd_busy1", n, 32'(read_busy1), 32'(model_busy(int'(read_reg1))));
      check("rnd_busy2", n, 32'(read_busy2), 32'(model_busy(int'(read_reg2))));
      check("rnd_count", n, 32'(busy_count), 32'(model_count()));
      model_edge();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
